fifo2apb: RTL and testbench

APB requester that drains a command FIFO, runs each command as one APB transfer (SETUP then ACCESS), and pushes one response word per transfer into a response FIFO. It is the initiator end of the APB link whose completer side is the team's APB-to-FIFO slave bridge. Both FIFOs use the team's standard FIFO (registered read, REQ/flag handshake).

---
 rtl/fifo2apb.sv | 151 +++++++++++++++
 tb/tb_fifo2apb.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo2apb.sv
// APB requester: pops commands from a FIFO, runs one SETUP/ACCESS transfer per
// command and pushes one {err, rdata} response word per transfer.
//
// state  | meaning
// IDLE   | no command in flight, waiting for CMD_EMPTY=0
// FETCH  | command word valid on CMD_RD, captured into hold registers
// SETUP  | PSEL=1, PENABLE=0
// ACCESS | PSEL=1, PENABLE=1, waiting for PREADY or timeout
// RESP   | response offered to the response FIFO; may prefetch next command
module fifo2apb #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic                     CMD_EMPTY,
  output logic                     CMD_RREQ,
  input  logic [ADDR_W+DATA_W:0]   CMD_RD,
  input  logic                     RSP_FULL,
  output logic                     RSP_WREQ,
  output logic [DATA_W:0]          RSP_WD,
  output logic                     PSEL,
  output logic                     PENABLE,
  output logic                     PWRITE,
  output logic [ADDR_W-1:0]        PADDR,
  output logic [DATA_W-1:0]        PWDATA,
  input  logic [DATA_W-1:0]        PRDATA,
  input  logic                     PREADY,
  input  logic                     PSLVERR,
  output logic                     BUSY,
  output logic [7:0]               ERR_CNT
);

  localparam int   TMO_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic TMO_EN = (TIMEOUT > 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t              state_q;
  logic                psel_q;
  logic                penable_q;
  logic                write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                err_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [TMO_W-1:0]    tmo_q;
  logic [7:0]          err_cnt_q;
  logic [7:0]          err_cnt_d;

  logic rsp_push;
  logic fetch_go;
  logic tmo_hit;

  // The FIFO read request must be combinational: the FIFO registers its
  // read data, so the word arrives in the cycle after the request.
  assign rsp_push = (state_q == S_RESP) && !RSP_FULL;
  assign fetch_go = !CMD_EMPTY && ((state_q == S_IDLE) || rsp_push);
  assign tmo_hit  = TMO_EN && (tmo_q == TMO_W'(1));

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (rsp_push && err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      tmo_q     <= '0;
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
      case (state_q)
        S_IDLE: begin
          if (!CMD_EMPTY) begin
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          write_q <= CMD_RD[ADDR_W+DATA_W];
          addr_q  <= CMD_RD[ADDR_W+DATA_W-1:DATA_W];
          wdata_q <= CMD_RD[DATA_W-1:0];
          psel_q  <= 1'b1;
          state_q <= S_SETUP;
        end
        S_SETUP: begin
          penable_q <= 1'b1;
          tmo_q     <= TMO_W'(TIMEOUT);
          state_q   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (PREADY) begin
            err_q     <= PSLVERR;
            rdata_q   <= write_q ? '0 : PRDATA;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            tmo_q     <= '0;
            state_q   <= S_RESP;
          end else if (tmo_hit) begin
            err_q     <= 1'b1;
            rdata_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            tmo_q     <= '0;
            state_q   <= S_RESP;
          end else begin
            tmo_q <= tmo_q - TMO_W'(1);
          end
        end
        S_RESP: begin
          if (!RSP_FULL) begin
            state_q <= CMD_EMPTY ? S_IDLE : S_FETCH;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign CMD_RREQ = fetch_go;
  assign RSP_WREQ = rsp_push;
  assign RSP_WD   = {err_q, rdata_q};
  assign PSEL     = psel_q;
  assign PENABLE  = penable_q;
  assign PWRITE   = write_q;
  assign PADDR    = addr_q;
  assign PWDATA   = wdata_q;
  assign BUSY     = (state_q != S_IDLE);
  assign ERR_CNT  = err_cnt_q;

endmodule

// File: tb/tb_fifo2apb.sv
// Directed bench for fifo2apb: emulates the command/response FIFOs and checks
// transfer timing, responses, timeout, backpressure, error counting and reset.
module tb_fifo2apb;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        CMD_EMPTY;
  logic        CMD_RREQ;
  logic [16:0] CMD_RD = '0;
  logic        RSP_FULL = 1'b0;
  logic        RSP_WREQ;
  logic [8:0]  RSP_WD;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR, PWDATA;
  logic [7:0]  PRDATA = 8'h00;
  logic        PREADY = 1'b1;
  logic        PSLVERR = 1'b0;
  logic        BUSY;
  logic [7:0]  ERR_CNT;

  fifo2apb #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .CMD_EMPTY(CMD_EMPTY), .CMD_RREQ(CMD_RREQ), .CMD_RD(CMD_RD),
    .RSP_FULL(RSP_FULL), .RSP_WREQ(RSP_WREQ), .RSP_WD(RSP_WD),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR),
    .BUSY(BUSY), .ERR_CNT(ERR_CNT)
  );

  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // command FIFO with registered read
  logic [16:0] cmd_mem [0:511];
  int pushed = 0;
  int popped = 0;
  assign CMD_EMPTY = (pushed == popped);

  always @(posedge PCLK) begin
    cyc <= cyc + 1;
    if (CMD_RREQ) begin
      CMD_RD <= cmd_mem[popped % 512];
      popped <= popped + 1;
    end
  end

  logic [8:0] rsp_mem [0:511];
  int         rsp_cyc [0:511];
  int         rsp_n = 0;
  always @(posedge PCLK) begin
    if (RSP_WREQ) begin
      rsp_mem[rsp_n % 512] <= RSP_WD;
      rsp_cyc[rsp_n % 512] <= cyc;
      rsp_n <= rsp_n + 1;
    end
  end

  // protocol rules sampled on every edge
  int   viol = 0;
  logic psel_p = 1'b0, pen_p = 1'b0;
  always @(posedge PCLK) begin
    if ((CMD_RREQ && CMD_EMPTY) || (RSP_WREQ && RSP_FULL) || (PENABLE && !PSEL) ||
        (PENABLE && !pen_p && !psel_p) || (PSEL && psel_p && !pen_p && !PENABLE))
      viol <= viol + 1;
    psel_p <= PSEL;
    pen_p  <= PENABLE;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge PCLK);
  endtask

  task automatic push(input logic w, input logic [7:0] a, input logic [7:0] d);
    cmd_mem[pushed % 512] = {w, a, d};
    pushed++;
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int n = 0;
    while (rsp_n < target && n < budget) begin
      @(negedge PCLK);
      n++;
    end
    chk("rsp_wait", (rsp_n >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  int b;

  initial begin
    repeat (3) tick();
    #1;
    chk("rst_ctrl", {PSEL, PENABLE, PWRITE, CMD_RREQ, RSP_WREQ, BUSY}, 6'b000000);
    chk("rst_data", {PADDR, PWDATA, RSP_WD, ERR_CNT}, 33'h0);
    tick(); PRESETn = 1'b1;
    tick(); #1;
    chk("idle_busy", BUSY, 1'b0);

    // single write, zero wait
    tick(); PRDATA = 8'hFF; push(1'b1, 8'h05, 8'hA5); #1;
    chk("w_rreq", {CMD_RREQ, BUSY}, 2'b10);
    tick(); #1;
    chk("w_fetch", {BUSY, PSEL, CMD_RREQ}, 3'b100);
    tick(); #1;
    chk("w_setup", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {1'b1, 1'b0, 1'b1, 8'h05, 8'hA5});
    tick(); #1;
    chk("w_access", {PSEL, PENABLE}, 2'b11);
    tick(); #1;
    chk("w_resp", {RSP_WREQ, RSP_WD, PSEL}, {1'b1, 9'h000, 1'b0});
    tick(); #1;
    chk("w_done", {BUSY, RSP_WREQ, ERR_CNT, PADDR}, {1'b0, 1'b0, 8'd0, 8'h05});

    // read with 3 wait states and slave error
    tick(); PREADY = 1'b0; PRDATA = 8'h00; push(1'b0, 8'h10, 8'h00); #1;
    chk("r_rreq", CMD_RREQ, 1'b1);
    tick();
    tick(); #1;
    chk("r_setup", {PSEL, PENABLE, PWRITE, PADDR}, {1'b1, 1'b0, 1'b0, 8'h10});
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("r_wait", {PSEL, PENABLE, RSP_WREQ}, 3'b110);
    end
    tick(); PREADY = 1'b1; PRDATA = 8'h3C; PSLVERR = 1'b1; #1;
    chk("r_acc4", {PSEL, PENABLE, RSP_WREQ}, 3'b110);
    tick(); PREADY = 1'b0; PRDATA = 8'h00; PSLVERR = 1'b0; #1;
    chk("r_resp", {RSP_WREQ, RSP_WD, ERR_CNT}, {1'b1, 9'h13C, 8'd0});
    tick(); #1;
    chk("r_errcnt", {ERR_CNT, BUSY}, {8'd1, 1'b0});

    // timeout, then a queued write proceeds
    tick(); push(1'b0, 8'h20, 8'h00); push(1'b1, 8'h21, 8'h5A); #1;
    chk("t_rreq", CMD_RREQ, 1'b1);
    tick();
    tick(); #1;
    chk("t_setup", {PSEL, PENABLE, PADDR}, {1'b1, 1'b0, 8'h20});
    for (int i = 0; i < 16; i++) begin
      tick(); #1;
      chk("t_access", {PSEL, PENABLE, RSP_WREQ}, 3'b110);
    end
    tick(); #1;
    chk("t_resp", {RSP_WREQ, RSP_WD, CMD_RREQ, PSEL}, {1'b1, 9'h100, 1'b1, 1'b0});
    tick(); PREADY = 1'b1; #1;
    chk("t_errcnt", {ERR_CNT, BUSY, PSEL}, {8'd2, 1'b1, 1'b0});
    tick(); #1;
    chk("t_next_setup", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {1'b1, 1'b0, 1'b1, 8'h21, 8'h5A});
    tick(); #1;
    chk("t_next_access", PENABLE, 1'b1);
    tick(); #1;
    chk("t_next_resp", {RSP_WREQ, RSP_WD}, {1'b1, 9'h000});
    tick(); #1;
    chk("t_done", {BUSY, ERR_CNT}, {1'b0, 8'd2});

    // backpressure on the first of three queued writes
    b = rsp_n;
    tick(); push(1'b1, 8'h30, 8'h11); push(1'b1, 8'h31, 8'h22); push(1'b1, 8'h32, 8'h33); #1;
    chk("bp_rreq", CMD_RREQ, 1'b1);
    tick();
    tick(); #1;
    chk("bp_setup0", {PSEL, PADDR, PWDATA}, {1'b1, 8'h30, 8'h11});
    tick(); #1;
    chk("bp_access0", PENABLE, 1'b1);
    tick(); RSP_FULL = 1'b1; #1;
    chk("bp_hold", {RSP_WREQ, CMD_RREQ, BUSY, PSEL}, 4'b0010);
    for (int i = 1; i < 5; i++) begin
      tick(); #1;
      chk("bp_hold", {RSP_WREQ, CMD_RREQ, BUSY, PSEL}, 4'b0010);
    end
    tick(); RSP_FULL = 1'b0; #1;
    chk("bp_resp0", {RSP_WREQ, CMD_RREQ, RSP_WD}, {2'b11, 9'h000});
    tick();
    tick(); #1;
    chk("bp_setup1", {PSEL, PENABLE, PADDR, PWDATA}, {2'b10, 8'h31, 8'h22});
    tick();
    tick(); #1;
    chk("bp_resp1", {RSP_WREQ, CMD_RREQ}, 2'b11);
    tick();
    tick(); #1;
    chk("bp_setup2", {PSEL, PADDR, PWDATA}, {1'b1, 8'h32, 8'h33});
    tick();
    tick(); #1;
    chk("bp_resp2", {RSP_WREQ, CMD_RREQ}, 2'b10);
    tick(); #1;
    chk("bp_idle", BUSY, 1'b0);
    chk("bp_count", rsp_n - b, 32'd3);
    chk("bp_gap1", rsp_cyc[(b + 1) % 512] - rsp_cyc[b % 512], 32'd4);
    chk("bp_gap2", rsp_cyc[(b + 2) % 512] - rsp_cyc[(b + 1) % 512], 32'd4);

    // 300 erroring reads: counter saturates
    b = rsp_n;
    tick(); PSLVERR = 1'b1; PRDATA = 8'h77; PREADY = 1'b1;
    for (int i = 0; i < 300; i++) push(1'b0, i[7:0], 8'h00);
    wait_rsp(b + 252, 1200); #1;
    chk("sat_254", ERR_CNT, 8'd254);
    wait_rsp(b + 253, 40); #1;
    chk("sat_255", ERR_CNT, 8'd255);
    wait_rsp(b + 300, 400); #1;
    chk("sat_hold", ERR_CNT, 8'd255);
    chk("sat_last_wd", rsp_mem[(b + 299) % 512], 9'h177);
    chk("sat_gap", rsp_cyc[(b + 299) % 512] - rsp_cyc[(b + 298) % 512], 32'd4);
    tick(); tick(); #1;
    chk("sat_idle", BUSY, 1'b0);

    // asynchronous reset in the middle of ACCESS
    tick(); PSLVERR = 1'b0; PREADY = 1'b0; push(1'b1, 8'h44, 8'h99);
    tick();
    tick();
    tick(); #1;
    chk("rst_pre", {PSEL, PENABLE}, 2'b11);
    #2 PRESETn = 1'b0;
    #1;
    chk("rst_mid_ctrl", {PSEL, PENABLE, BUSY, PWRITE, CMD_RREQ, RSP_WREQ}, 6'b000000);
    chk("rst_mid_data", {PADDR, PWDATA, RSP_WD, ERR_CNT}, 33'h0);
    tick(); PRESETn = 1'b1;
    tick(); #1;
    chk("rst_after", {BUSY, CMD_RREQ, PSEL}, 3'b000);

    chk("protocol_viol", viol, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
